// File: rtl/lcd_cmd_sequencer.sv
// HD44780-style command sequencer: power-on init ROM, character writes with
// line wrapping, and clear/home, handed one command at a time to an instruction FSM.
module lcd_cmd_sequencer #(
    parameter int POWERUP_CYCLES    = 750000,
    parameter int CMD_WAIT_CYCLES   = 2000,
    parameter int CLEAR_WAIT_CYCLES = 82000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_req,
    input  logic [7:0] wr_char,
    input  logic       clr_req,
    output logic       wr_ready,
    output logic       init_done,
    output logic [9:0] data,
    output logic       ENABLE,
    input  logic       FSM_done
);

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT_ISSUE,
        IDLE,
        ISSUE,
        WAIT_DONE,
        SETTLE,
        ADDR_FIX
    } state_t;

    localparam logic [31:0] PWR_LAST   = 32'(POWERUP_CYCLES - 1);
    localparam logic [31:0] CMD_LAST   = 32'(CMD_WAIT_CYCLES - 1);
    localparam logic [31:0] CLEAR_LAST = 32'(CLEAR_WAIT_CYCLES - 1);

    state_t      state, state_next;
    logic [31:0] cnt, cnt_next;
    logic [1:0]  init_idx, init_idx_next;
    logic [4:0]  cursor, cursor_next;
    logic [9:0]  data_next;
    logic        init_done_next;
    logic        long_settle;
    logic [31:0] settle_last;

    function automatic logic [7:0] init_rom(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h28;  // 4-bit bus, 2 lines, 5x8 font
            2'd1:    return 8'h06;  // entry mode: increment, no shift
            2'd2:    return 8'h0C;  // display on, cursor off
            default: return 8'h01;  // clear display
        endcase
    endfunction

    assign ENABLE   = (state == ISSUE) || (state == WAIT_DONE);
    assign wr_ready = (state == IDLE) && init_done;

    // Clear and Return Home need the long execution time; everything else is short.
    assign long_settle = !data[9] && ((data[7:0] == 8'h01) || (data[7:0] == 8'h02));
    assign settle_last = long_settle ? CLEAR_LAST : CMD_LAST;

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        init_idx_next  = init_idx;
        cursor_next    = cursor;
        data_next      = data;
        init_done_next = init_done;
        case (state)
            PWR_WAIT: begin
                if (cnt == PWR_LAST) begin
                    cnt_next   = '0;
                    state_next = INIT_ISSUE;
                end else begin
                    cnt_next = cnt + 32'd1;
                end
            end
            INIT_ISSUE: begin
                data_next  = {2'b00, init_rom(init_idx)};
                state_next = ISSUE;
            end
            IDLE: begin
                if (wr_ready && clr_req) begin
                    data_next   = 10'h001;
                    cursor_next = '0;
                    state_next  = ISSUE;
                end else if (wr_ready && wr_req) begin
                    data_next   = {2'b10, wr_char};
                    cursor_next = cursor + 5'd1;
                    state_next  = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (FSM_done) begin
                    cnt_next   = '0;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == settle_last) begin
                    cnt_next = '0;
                    if (!init_done) begin
                        if (init_idx == 2'd3) begin
                            init_done_next = 1'b1;
                            cursor_next    = '0;
                            state_next     = IDLE;
                        end else begin
                            init_idx_next = init_idx + 2'd1;
                            state_next    = INIT_ISSUE;
                        end
                    end else if (data[9] && ((cursor == 5'd16) || (cursor == 5'd0))) begin
                        // A character just crossed into line 2 or wrapped back to line 1.
                        state_next = ADDR_FIX;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt + 32'd1;
                end
            end
            ADDR_FIX: begin
                data_next  = (cursor == 5'd16) ? 10'h0C0 : 10'h080;
                state_next = ISSUE;
            end
            default: begin
                state_next = PWR_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= PWR_WAIT;
            cnt       <= '0;
            init_idx  <= '0;
            cursor    <= '0;
            data      <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            init_idx  <= init_idx_next;
            cursor    <= cursor_next;
            data      <= data_next;
            init_done <= init_done_next;
        end
    end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Directed bench for lcd_cmd_sequencer with short wait parameters and an
// instruction-FSM responder that acknowledges each ENABLE after ack_delay cycles.
module tb_lcd_cmd_sequencer;

    localparam int PWR  = 20;
    localparam int CMDW = 6;
    localparam int CLRW = 12;
    localparam int LIM  = 2000;

    logic       clk = 1'b0;
    logic       reset, wr_req, clr_req, ack, spur;
    logic [7:0] wr_char;
    logic       wr_ready, init_done, ENABLE;
    logic [9:0] data;

    int total = 0;
    int bad   = 0;
    int ack_delay = 5;

    bit   pend;
    int   rcnt;
    logic prev_en;

    lcd_cmd_sequencer #(
        .POWERUP_CYCLES   (PWR),
        .CMD_WAIT_CYCLES  (CMDW),
        .CLEAR_WAIT_CYCLES(CLRW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_req   (wr_req),
        .wr_char  (wr_char),
        .clr_req  (clr_req),
        .wr_ready (wr_ready),
        .init_done(init_done),
        .data     (data),
        .ENABLE   (ENABLE),
        .FSM_done (ack | spur)
    );

    always #5 clk = ~clk;

    // Instruction-FSM model: one-cycle done pulse ack_delay cycles after ENABLE rises.
    initial begin
        ack = 1'b0; pend = 1'b0; rcnt = 0; prev_en = 1'b0;
        forever begin
            @(negedge clk);
            ack = 1'b0;
            if (reset) begin
                pend = 1'b0;
                rcnt = 0;
            end else begin
                if (pend) begin
                    rcnt = rcnt - 1;
                    if (rcnt <= 0) begin
                        ack  = 1'b1;
                        pend = 1'b0;
                    end
                end
                if (ENABLE && !prev_en) begin
                    pend = 1'b1;
                    rcnt = ack_delay;
                end
            end
            prev_en = ENABLE;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit clr, input bit wr, input logic [7:0] c);
        int n;
        n = 0;
        while (!wr_ready && n < LIM) begin
            tick();
            n++;
        end
        clr_req = clr;
        wr_req  = wr;
        wr_char = c;
        tick();
        clr_req = 1'b0;
        wr_req  = 1'b0;
    endtask

    // Captures one command: its data, ENABLE high length, and the settle gap
    // until either wr_ready or the next ENABLE. poke injects a spurious done
    // plus an (ignored) write request in the first settle cycle.
    task automatic capture(input bit poke, output logic [9:0] d, output int en_len,
                           output int gap, output bit stable, output bit to);
        int n;
        to = 1'b0; stable = 1'b1; en_len = 0; gap = 0; d = '0; n = 0;
        while (!ENABLE && n < LIM) begin
            tick();
            n++;
        end
        if (!ENABLE) begin
            to = 1'b1;
            return;
        end
        d = data;
        while (ENABLE && en_len < LIM) begin
            if (data !== d) stable = 1'b0;
            en_len++;
            tick();
        end
        if (poke) begin
            spur    = 1'b1;
            wr_req  = 1'b1;
            wr_char = 8'h7E;
            tick();
            spur   = 1'b0;
            wr_req = 1'b0;
            gap    = 1;
        end
        while (!wr_ready && !ENABLE && gap < LIM) begin
            if (data !== d) stable = 1'b0;
            tick();
            gap++;
        end
        if (gap >= LIM || en_len >= LIM) to = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_req = 1'b0; clr_req = 1'b0; spur = 1'b0; wr_char = '0;
        repeat (3) tick();
        total++; if (ENABLE !== 1'b0) begin bad++; $display("FAIL reset_enable: got %b want 0", ENABLE); end
        total++; if (data !== 10'h000) begin bad++; $display("FAIL reset_data: got %h want 000", data); end
        total++; if (init_done !== 1'b0) begin bad++; $display("FAIL reset_init_done: got %b want 0", init_done); end
        total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready); end
    endtask

    task automatic test_init();
        logic [9:0] exp_cmd [4];
        logic [9:0] d;
        int n, en_len, gap, exp_gap;
        bit stable, to;
        exp_cmd = '{10'h028, 10'h006, 10'h00C, 10'h001};
        reset = 1'b0;
        n = 0;
        while (!ENABLE && n < LIM) begin
            tick();
            n++;
        end
        total++; if (!(n >= PWR && n < LIM)) begin bad++; $display("FAIL init_powerup_wait: got %0d cycles want >= %0d", n, PWR); end
        for (int i = 0; i < 4; i++) begin
            capture(1'b0, d, en_len, gap, stable, to);
            exp_gap = (i < 3) ? CMDW + 1 : CLRW;
            total++; if (to !== 1'b0) begin bad++; $display("FAIL init_timeout[%0d]: got %b want 0", i, to); end
            total++; if (d !== exp_cmd[i]) begin bad++; $display("FAIL init_cmd[%0d]: got %h want %h", i, d, exp_cmd[i]); end
            total++; if (gap !== exp_gap) begin bad++; $display("FAIL init_settle[%0d]: got %0d want %0d", i, gap, exp_gap); end
        end
        total++; if (init_done !== 1'b1) begin bad++; $display("FAIL init_done: got %b want 1", init_done); end
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL init_wr_ready: got %b want 1", wr_ready); end
    endtask

    task automatic test_char();
        logic [9:0] d;
        int en_len, gap;
        bit stable, to;
        send(1'b0, 1'b1, 8'h41);
        capture(1'b0, d, en_len, gap, stable, to);
        total++; if (d !== 10'h241) begin bad++; $display("FAIL char_data: got %h want 241", d); end
        total++; if (en_len !== 6) begin bad++; $display("FAIL char_enable_len: got %0d want 6", en_len); end
        total++; if (stable !== 1'b1) begin bad++; $display("FAIL char_stable: got %b want 1", stable); end
        total++; if (gap !== CMDW) begin bad++; $display("FAIL char_settle: got %0d want %0d", gap, CMDW); end
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL char_ready: got %b want 1", wr_ready); end
    endtask

    task automatic test_clear_priority();
        logic [9:0] d;
        int en_len, gap;
        bit stable, to, quiet;
        send(1'b1, 1'b1, 8'h55);
        capture(1'b0, d, en_len, gap, stable, to);
        total++; if (d !== 10'h001) begin bad++; $display("FAIL clr_data: got %h want 001", d); end
        total++; if (gap !== CLRW) begin bad++; $display("FAIL clr_settle: got %0d want %0d", gap, CLRW); end
        quiet = 1'b1;
        repeat (8) begin
            if (ENABLE !== 1'b0) quiet = 1'b0;
            tick();
        end
        total++; if (quiet !== 1'b1) begin bad++; $display("FAIL clr_dropped_write: got %b want 1", quiet); end
    endtask

    task automatic test_slow_ack();
        logic [9:0] d;
        int en_len, gap;
        bit stable, to, quiet;
        ack_delay = 100;
        send(1'b0, 1'b1, 8'h5A);
        capture(1'b1, d, en_len, gap, stable, to);
        ack_delay = 5;
        total++; if (d !== 10'h25A) begin bad++; $display("FAIL slow_data: got %h want 25a", d); end
        total++; if (en_len !== 101) begin bad++; $display("FAIL slow_enable_len: got %0d want 101", en_len); end
        total++; if (stable !== 1'b1) begin bad++; $display("FAIL slow_stable: got %b want 1", stable); end
        total++; if (gap !== CMDW) begin bad++; $display("FAIL slow_settle_spurious: got %0d want %0d", gap, CMDW); end
        quiet = 1'b1;
        repeat (8) begin
            if (ENABLE !== 1'b0) quiet = 1'b0;
            tick();
        end
        total++; if (quiet !== 1'b1) begin bad++; $display("FAIL busy_request_ignored: got %b want 1", quiet); end
    endtask

    task automatic test_line_wrap();
        logic [9:0] d, exp_fix;
        logic [7:0] c;
        int en_len, gap;
        bit stable, to;
        send(1'b1, 1'b0, 8'h00);
        capture(1'b0, d, en_len, gap, stable, to);
        total++; if (d !== 10'h001) begin bad++; $display("FAIL wrap_clear: got %h want 001", d); end
        for (int i = 1; i <= 32; i++) begin
            c = 8'h40 + 8'(i);
            send(1'b0, 1'b1, c);
            capture(1'b0, d, en_len, gap, stable, to);
            total++; if (d !== {2'b10, c}) begin bad++; $display("FAIL wrap_char[%0d]: got %h want %h", i, d, {2'b10, c}); end
            if (i == 16 || i == 32) begin
                total++; if (gap !== CMDW + 1) begin bad++; $display("FAIL wrap_gap[%0d]: got %0d want %0d", i, gap, CMDW + 1); end
                exp_fix = (i == 16) ? 10'h0C0 : 10'h080;
                capture(1'b0, d, en_len, gap, stable, to);
                total++; if (d !== exp_fix) begin bad++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, d, exp_fix); end
                total++; if (gap !== CMDW) begin bad++; $display("FAIL wrap_addr_settle[%0d]: got %0d want %0d", i, gap, CMDW); end
            end else begin
                total++; if (gap !== CMDW) begin bad++; $display("FAIL wrap_settle[%0d]: got %0d want %0d", i, gap, CMDW); end
            end
        end
        total++; if (dut.cursor !== 5'd0) begin bad++; $display("FAIL wrap_cursor: got %0d want 0", dut.cursor); end
    endtask

    task automatic test_reset_mid();
        logic [9:0] d;
        int n, en_len, gap;
        bit stable, to;
        ack_delay = 200;
        send(1'b0, 1'b1, 8'h33);
        repeat (3) tick();
        total++; if (ENABLE !== 1'b1) begin bad++; $display("FAIL mid_enable_before: got %b want 1", ENABLE); end
        reset = 1'b1;
        tick();
        total++; if (ENABLE !== 1'b0) begin bad++; $display("FAIL mid_enable_after: got %b want 0", ENABLE); end
        total++; if (init_done !== 1'b0) begin bad++; $display("FAIL mid_init_done: got %b want 0", init_done); end
        total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL mid_wr_ready: got %b want 0", wr_ready); end
        reset = 1'b0;
        ack_delay = 5;
        n = 0;
        while (!ENABLE && n < LIM) begin
            tick();
            n++;
        end
        total++; if (!(n >= PWR && n < LIM)) begin bad++; $display("FAIL mid_powerup_wait: got %0d cycles want >= %0d", n, PWR); end
        capture(1'b0, d, en_len, gap, stable, to);
        total++; if (d !== 10'h028) begin bad++; $display("FAIL mid_replay: got %h want 028", d); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_char();
        test_clear_priority();
        test_slow_ack();
        test_line_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_cmd_sequencer.md
LCD_CMD_SEQUENCER -- requirements
Module: lcd_cmd_sequencer

Interface
REQ-001 Parameter POWERUP_CYCLES, default 750000, means the power-on wait before the first command (15 ms at 50 MHz).
REQ-002 Parameter CMD_WAIT_CYCLES, default 2000, means the post-command settle time for ordinary commands and characters (40 us).
REQ-003 Parameter CLEAR_WAIT_CYCLES, default 82000, means the post-command settle time after Clear Display (0x01) and Return Home (0x02) (1.64 ms).
REQ-004 clk  in  1  system clock; all logic rising-edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 wr_req  in  1  host request to write one character.
REQ-007 wr_char  in  8  character code, sampled with wr_req.
REQ-008 clr_req  in  1  host request to clear the display and home the cursor.
REQ-009 wr_ready  out  1  high when a host request is accepted this cycle.
REQ-010 init_done  out  1  high once the init sequence has completed; stays high until reset.
REQ-011 data  out  10  command to the instruction FSM: [9]=RS, [8]=RW, [7:0]=byte.
REQ-012 ENABLE  out  1  command strobe to the instruction FSM.
REQ-013 FSM_done  in  1  instruction FSM completion pulse.

Function
REQ-014 The state machine SHALL have the states PWR_WAIT, INIT_ISSUE, IDLE, ISSUE, WAIT_DONE, SETTLE and ADDR_FIX.
REQ-015 PWR_WAIT SHALL count POWERUP_CYCLES clocks and then go to INIT_ISSUE.
REQ-016 The init ROM SHALL issue, in order, 0x28, 0x06, 0x0C, 0x01 with RS=0 and RW=0, each followed by its settle time.
REQ-017 After the fourth init command settles, the block SHALL set init_done=1 and enter IDLE with cursor=0.
REQ-018 ISSUE SHALL drive data and set ENABLE=1 for one cycle, then go to WAIT_DONE.
REQ-019 In WAIT_DONE, ENABLE and data SHALL be held stable until FSM_done=1 is sampled.
REQ-020 On FSM_done, ENABLE SHALL go low on the following cycle and the block SHALL enter SETTLE.
REQ-021 The SETTLE wait SHALL be CLEAR_WAIT_CYCLES when data[7:0] is 0x01 or 0x02 with RS=0, and CMD_WAIT_CYCLES otherwise.
REQ-022 wr_ready SHALL be high only in IDLE with init_done=1; it is combinational from state.
REQ-023 In IDLE, clr_req SHALL have priority over wr_req when both are high; the lower-priority request is dropped and not queued.
REQ-024 An accepted wr_req SHALL issue {RS=1, RW=0, wr_char} and increment a 5-bit cursor (0..31).
REQ-025 An accepted clr_req SHALL issue 0x001 and reset the cursor to 0.
REQ-026 After a character write, when the cursor becomes 16 the block SHALL enter ADDR_FIX and issue Set DDRAM 0xC0 (data=0x0C0).
REQ-027 After a character write, when the cursor wraps from 31 to 0 the block SHALL enter ADDR_FIX and issue 0x080.
REQ-028 ADDR_FIX SHALL use the normal ISSUE/WAIT_DONE/SETTLE path before returning to IDLE.
REQ-029 FSM_done arriving in any state other than WAIT_DONE SHALL be ignored.
REQ-030 Requests arriving while wr_ready=0 SHALL be ignored; the host must hold the request until it sees wr_ready=1.
REQ-031 RW SHALL always be 0, because the block never reads the busy flag.

Reset
REQ-032 While reset=1, the block SHALL drive state=PWR_WAIT, all counters=0, cursor=0, ENABLE=0, data=0, init_done=0 and wr_ready=0.
REQ-033 A reset asserted mid-command SHALL abort the command within one cycle and restart the full power-on sequence.

Verification
REQ-034 Reset, then auto-acknowledge FSM_done 5 cycles after each ENABLE -> 0x028, 0x006, 0x00C, 0x001 appear in order; the first ENABLE comes no earlier than POWERUP_CYCLES; init_done=1 after the last settle.
REQ-035 After init, wr_req with 0x41 -> data=0x241; ENABLE held until FSM_done; SETTLE lasts CMD_WAIT_CYCLES; wr_ready returns to 1.
REQ-036 Sixteen character writes -> a 0x0C0 command follows the 16th; after 32 writes -> 0x080; cursor=0.
REQ-037 clr_req and wr_req high in the same IDLE cycle -> only 0x001 is issued; the SETTLE length equals CLEAR_WAIT_CYCLES.
REQ-038 Delay FSM_done by 100 cycles and inject a spurious FSM_done during SETTLE -> data and ENABLE stay stable for the whole wait; the spurious pulse has no effect.
REQ-039 Assert reset during WAIT_DONE -> ENABLE=0 on the next cycle, init_done=0, and the init sequence replays from 0x028.
